// File: rtl/uart_rx_ctrl.sv
// UART config-link frame parser: hunts HEAD0 HEAD1 ADDR DATAL DATAH and issues one write per frame.
// Latency: write request valid one cycle after the DATAH strobe; inbound bytes have no back-pressure, so frames completing while a write is pending are dropped and counted.
module uart_rx_ctrl #(
    parameter logic [7:0]  UART_HEAD0     = 8'hFF,
    parameter logic [7:0]  UART_HEAD1     = 8'hAA,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic [7:0]  reg_cfg_addr,
    output logic [15:0] reg_cfg_value,
    output logic        reg_cfg_req,
    input  logic        reg_cfg_ack,
    output logic        rx_busy,
    output logic [7:0]  timeout_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {S_HEAD0, S_HEAD1, S_ADDR, S_DATAL, S_DATAH} state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  addr_lat_q, addr_lat_d;
    logic [7:0]  datal_lat_q, datal_lat_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic [15:0] cfg_value_q, cfg_value_d;
    logic        req_q, req_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        timeout;
    logic        frame_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HEAD0;
            timer_q     <= '0;
            addr_lat_q  <= '0;
            datal_lat_q <= '0;
            cfg_addr_q  <= '0;
            cfg_value_q <= '0;
            req_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            addr_lat_q  <= addr_lat_d;
            datal_lat_q <= datal_lat_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_value_q <= cfg_value_d;
            req_q       <= req_d;
            tmo_cnt_q   <= tmo_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        addr_lat_d  = addr_lat_q;
        datal_lat_d = datal_lat_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_value_d = cfg_value_q;
        req_d       = req_q;
        tmo_cnt_d   = tmo_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        // A byte on the expiry cycle takes priority, so timeout requires rx_vld low.
        timeout    = (state_q != S_HEAD0) && !rx_vld && (timer_q == TIMEOUT_CYCLES - 16'd1);
        frame_done = rx_vld && (state_q == S_DATAH);

        if (rx_vld || state_q == S_HEAD0) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        if (rx_vld) begin
            unique case (state_q)
                S_HEAD0: if (rx_data == UART_HEAD0) state_d = S_HEAD1;
                S_HEAD1: begin
                    if (rx_data == UART_HEAD1)      state_d = S_ADDR;
                    else if (rx_data != UART_HEAD0) state_d = S_HEAD0;
                end
                S_ADDR: begin
                    addr_lat_d = rx_data;
                    state_d    = S_DATAL;
                end
                S_DATAL: begin
                    datal_lat_d = rx_data;
                    state_d     = S_DATAH;
                end
                S_DATAH: state_d = S_HEAD0;
                default: state_d = S_HEAD0;
            endcase
        end else if (timeout) begin
            state_d     = S_HEAD0;
            timer_d     = '0;
            addr_lat_d  = '0;
            datal_lat_d = '0;
            if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        end

        // An ack in the completion cycle frees the slot for the new frame.
        if (frame_done && (!req_q || reg_cfg_ack)) begin
            cfg_addr_d  = addr_lat_q;
            cfg_value_d = {rx_data, datal_lat_q};
            req_d       = 1'b1;
        end else if (frame_done) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (req_q && reg_cfg_ack) begin
            req_d = 1'b0;
        end
    end

    assign reg_cfg_addr  = cfg_addr_q;
    assign reg_cfg_value = cfg_value_q;
    assign reg_cfg_req   = req_q;
    assign rx_busy       = (state_q != S_HEAD0);
    assign timeout_cnt   = tmo_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: two instances (default timeout and an 8-cycle timeout), directed frames,
// expected writes queued by the stimulus and consumed by a negedge monitor.
module tb_uart_rx_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        vld [2];
    logic        ack [2];
    logic [7:0]  addr_o [2];
    logic [15:0] val_o [2];
    logic        req_o [2];
    logic        busy_o [2];
    logic [7:0]  tmo_o [2];
    logic [7:0]  drop_o [2];

    int tests = 0;
    int fails = 0;
    logic [23:0] exp0 [$];
    logic [23:0] exp1 [$];
    int   req_hi [2];
    logic prev_req [2];
    logic prev_ack [2];

    uart_rx_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(vld[0]),
        .reg_cfg_addr(addr_o[0]), .reg_cfg_value(val_o[0]), .reg_cfg_req(req_o[0]),
        .reg_cfg_ack(ack[0]), .rx_busy(busy_o[0]), .timeout_cnt(tmo_o[0]), .drop_cnt(drop_o[0])
    );

    uart_rx_ctrl #(.TIMEOUT_CYCLES(16'd8)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(vld[1]),
        .reg_cfg_addr(addr_o[1]), .reg_cfg_value(val_o[1]), .reg_cfg_req(req_o[1]),
        .reg_cfg_ack(ack[1]), .rx_busy(busy_o[1]), .timeout_cnt(tmo_o[1]), .drop_cnt(drop_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A new write is presented when req is high and either it was low or an ack was taken last cycle.
    initial begin
        req_hi   = '{0, 0};
        prev_req = '{1'b0, 1'b0};
        prev_ack = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_o[i] === 1'b1 && (!prev_req[i] || prev_ack[i])) begin
                    logic [23:0] e;
                    logic        have;
                    have = (i == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
                    if (!have) begin
                        check($sformatf("unexpected_write%0d", i), {addr_o[i], val_o[i]}, 24'hxxxxxx);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        check($sformatf("write%0d", i), {8'h0, addr_o[i], val_o[i]}, {8'h0, e});
                    end
                end
                if (req_o[i] === 1'b1) req_hi[i]++;
                prev_req[i] = req_o[i];
                prev_ack[i] = ack[i];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic [7:0] b, input logic a = 1'b0);
        rx_data = b;
        vld[d]  = 1'b1;
        ack[d]  = a;
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        ack[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [7:0] a, input logic [7:0] lo,
                              input logic [7:0] hi, input int gap);
        send(d, 8'hFF); idle(gap);
        send(d, 8'hAA); idle(gap);
        send(d, a);     idle(gap);
        send(d, lo);    idle(gap);
        send(d, hi);
    endtask

    task automatic ack_pulse(input int d);
        ack[d] = 1'b1;
        @(posedge clk);
        #1;
        ack[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int hi0;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        vld     = '{1'b0, 1'b0};
        ack     = '{1'b0, 1'b0};
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_outs%0d", i),
                  {busy_o[i], req_o[i], addr_o[i], val_o[i]}, 32'h0);
            check($sformatf("rst_cnts%0d", i), {tmo_o[i], drop_o[i]}, 16'h0);
        end

        // Single frame with 10-cycle strobe spacing; ack sampled 3 cycles after req rises.
        exp0.push_back({8'h12, 16'h5634});
        send(0, 8'hFF); idle(9);
        send(0, 8'hAA); idle(9);
        send(0, 8'h12); idle(9);
        send(0, 8'h34); idle(9);
        hi0 = req_hi[0];
        send(0, 8'h56);
        idle(2);
        ack_pulse(0);
        idle(2);
        check("req_pulse_len", req_hi[0] - hi0, 3);
        check("req_after_ack", req_o[0], 1'b0);
        check("value_held", {addr_o[0], val_o[0]}, {8'h12, 16'h5634});
        check("single_cnts", {tmo_o[0], drop_o[0]}, 16'h0);

        // Noise and header resync.
        exp0.push_back({8'h07, 16'h8001});
        send(0, 8'h00); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'hAA);
        send(0, 8'h07); send(0, 8'h01); send(0, 8'h80);
        idle(1);
        ack_pulse(0);
        exp0.push_back({8'h09, 16'h0000});
        send(0, 8'hFF); send(0, 8'h55); send(0, 8'hFF); send(0, 8'hAA);
        send(0, 8'h09); send(0, 8'h00); send(0, 8'h00);
        idle(1);
        ack_pulse(0);
        idle(1);

        // Back-to-back with ack low: second frame dropped.
        exp0.push_back({8'hAA, 16'hFF11});
        send_frame(0, 8'hAA, 8'h11, 8'hFF, 0);
        send_frame(0, 8'h22, 8'h33, 8'h44, 0);
        idle(1);
        check("drop_held", {addr_o[0], val_o[0]}, {8'hAA, 16'hFF11});
        check("drop_cnt1", drop_o[0], 8'd1);
        ack_pulse(0);

        // Second DATAH coincides with the ack: new frame loaded, req stays high.
        do_reset();
        exp0.push_back({8'h01, 16'h0302});
        send_frame(0, 8'h01, 8'h02, 8'h03, 0);
        exp0.push_back({8'h04, 16'h0605});
        send(0, 8'hFF); send(0, 8'hAA); send(0, 8'h04); send(0, 8'h05);
        send(0, 8'h06, 1'b1);
        check("ack_same_cycle_req", req_o[0], 1'b1);
        check("ack_same_cycle_drop", drop_o[0], 8'd0);
        ack_pulse(0);
        idle(1);
        check("req_cleared", req_o[0], 1'b0);

        // Reset mid-frame after DATAL.
        send(0, 8'hFF); send(0, 8'hAA); send(0, 8'h12); send(0, 8'h34);
        check("busy_midframe", busy_o[0], 1'b1);
        do_reset();
        check("rst_mid_outs", {busy_o[0], req_o[0], addr_o[0], val_o[0]}, 32'h0);
        send(0, 8'h56);
        idle(2);
        check("rst_mid_no_req", {req_o[0], tmo_o[0], drop_o[0]}, 17'h0);

        // Drop counter saturation.
        exp0.push_back({8'h5A, 16'hC3A5});
        send_frame(0, 8'h5A, 8'hA5, 8'hC3, 0);
        for (int k = 0; k < 300; k++) send_frame(0, 8'h01, 8'h02, 8'h03, 0);
        idle(1);
        check("drop_sat", drop_o[0], 8'd255);
        check("drop_sat_held", {addr_o[0], val_o[0]}, {8'h5A, 16'hC3A5});
        ack_pulse(0);

        // Timeout with TIMEOUT_CYCLES=8.
        send(1, 8'hFF); send(1, 8'hAA); send(1, 8'h12);
        idle(7);
        check("tmo_not_yet", {busy_o[1], tmo_o[1]}, 9'h100);
        idle(1);
        check("tmo_fired", {busy_o[1], tmo_o[1]}, 9'h001);
        exp1.push_back({8'h21, 16'h6543});
        send_frame(1, 8'h21, 8'h43, 8'h65, 0);
        idle(1);
        ack_pulse(1);

        // Bytes arriving exactly when the timer reaches TIMEOUT_CYCLES-1.
        exp1.push_back({8'h31, 16'h0302});
        send_frame(1, 8'h31, 8'h02, 8'h03, 7);
        idle(1);
        check("boundary_tmo_cnt", tmo_o[1], 8'd1);
        check("boundary_req", req_o[1], 1'b1);
        ack_pulse(1);
        idle(3);

        check("exp0_drained", exp0.size(), 0);
        check("exp1_drained", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
